// File: rtl/apb_master.sv
// APB master bridge: turns single CPU requests into APB
// SETUP/ACCESS transfers with a bounded wait-state timeout.
module apb_master #(
    parameter int BUS_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] S_MEM_ADDR,
    input  logic [BUS_WIDTH-1:0] S_MEM_IN,
    input  logic                 S_MEM_WE,
    input  logic                 S_REQ,
    output logic [BUS_WIDTH-1:0] S_MEM_OUT,
    output logic                 S_ACK,
    output logic                 S_MEM_BUSY,
    output logic                 S_ERR,
    output logic [BUS_WIDTH-1:0] M_PADDR,
    output logic                 M_PWRITE,
    output logic                 M_PSELx,
    output logic                 M_PENABLE,
    output logic [BUS_WIDTH-1:0] M_PWDATA,
    input  logic [BUS_WIDTH-1:0] M_PRDATA,
    input  logic                 M_PREADY
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t               state_q, state_d;
    logic [7:0]           wait_q, wait_d;
    logic [BUS_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
    logic                 write_q, write_d;
    logic                 sel_q, sel_d;
    logic                 en_q, en_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        sel_d   = 1'b0;
        en_d    = 1'b0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (S_REQ) begin
                    state_d = SETUP;
                    wait_d  = '0;
                    addr_d  = S_MEM_ADDR;
                    wdata_d = S_MEM_IN;
                    write_d = S_MEM_WE;
                    sel_d   = 1'b1;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                sel_d   = 1'b1;
                en_d    = 1'b1;
            end
            ACCESS: begin
                // A ready on the final allowed cycle still wins.
                if (M_PREADY) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    if (!write_q) rdata_d = M_PRDATA;
                end else if (wait_q == TMO) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    wait_d = wait_q + 8'd1;
                    sel_d  = 1'b1;
                    en_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign S_MEM_OUT  = rdata_q;
    assign S_ACK      = ack_q;
    assign S_MEM_BUSY = busy_q;
    assign S_ERR      = err_q;
    assign M_PADDR    = addr_q;
    assign M_PWRITE   = write_q;
    assign M_PSELx    = sel_q;
    assign M_PENABLE  = en_q;
    assign M_PWDATA   = wdata_q;

endmodule
